// File: rtl/mem_access_unit.sv
// Load/store initiator for dataMemory: sub-word load extraction/extension and read-modify-write sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned half/word requests; otherwise their low address bits are forced to alignment.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    output logic              memWrite,
    input  logic [31:0]       readdata
);
    // state  | meaning
    // IDLE   | ready for a new request
    // RD     | load: address driven, readdata sampled at end of cycle
    // RMW_RD | sub-word store: read word, merge new lane
    // WR     | memWrite pulse with stable address/writedata
    // RESP   | one-cycle response strobe
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d, off_q, off_d;
    logic              uns_q, uns_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d, mem_write_q, mem_write_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d, writedata_q, writedata_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              req_err;
    logic [1:0]        req_off;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_data, merged;

`ifdef MAU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_err    = (req_size == 2'b11) || misaligned;
`else
    assign req_err    = (req_size == 2'b11);
`endif

    // Forcing the low bits is harmless in trap mode: misaligned requests never reach memory there.
    always_comb begin
        req_off = req_addr[1:0];
        if (req_size == 2'b01)
            req_off[0] = 1'b0;
        else if (req_size == 2'b10)
            req_off = 2'b00;
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = readdata[31:24];
            2'd1:    lane_b = readdata[23:16];
            2'd2:    lane_b = readdata[15:8];
            default: lane_b = readdata[7:0];
        endcase
        lane_h = off_q[1] ? readdata[15:0] : readdata[31:16];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = readdata;
        endcase
        merged = readdata;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[15:0] = wdata_q;
        end else begin
            merged[31:16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 16'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
            address_q    <= '0;
            writedata_q  <= 32'h0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            mem_write_q  <= mem_write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (!req_write)
                        state_d = S_RD;
                    else if (req_size == 2'b10)
                        state_d = S_WR;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_RD:     state_d = S_RESP;
            S_RMW_RD: state_d = S_WR;
            S_WR:     state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        resp_rdata_d = 32'h0;
        resp_error_d = 1'b0;
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_write_d  = (state_d == S_WR);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    off_d   = req_off;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    if (req_err) begin
                        resp_error_d = 1'b1;
                    end else begin
                        address_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_write && req_size == 2'b10)
                            writedata_d = req_wdata;
                    end
                end
            end
            S_RD:     resp_rdata_d = load_data;
            S_RMW_RD: writedata_d  = merged;
            default:  ;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign memWrite   = mem_write_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: owns a small dataMemory and compares against an arithmetic reference model.
// Honours MAU_MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error, memWrite;
    logic [31:0] resp_rdata, address, writedata, readdata;

    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .address(address), .writedata(writedata),
        .memWrite(memWrite), .readdata(readdata)
    );

    assign readdata = dut_mem[address[7:2]];

    always @(posedge clk)
        if (memWrite) dut_mem[address[7:2]] <= writedata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: expected response, latency and memory effect from the access rules.
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output int wrn, output logic [31:0] waddr);
        int          idx, off, sh;
        logic [31:0] w, v, mask;
        idx = int'(addr[7:2]);
        off = int'(addr[1:0]);
        err = (sz == 2'b11);
`ifdef MAU_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) err = 1'b1;
`else
        if (sz == 2'b01) off = off & 2;
        else if (sz == 2'b10) off = 0;
`endif
        rd = 32'h0; lat = 1; wrn = 0; waddr = addr & 32'hFFFF_FFFC;
        if (err) return;
        w = ref_mem[idx];
        if (!wr) begin
            lat = 2;
            if (sz == 2'b00) begin
                sh = 8 * (3 - off);
                v = (w >> sh) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                sh = 8 * (2 - off);
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            rd = v;
        end else begin
            wrn = 1;
            if (sz == 2'b10) begin
                lat = 2;
                ref_mem[idx] = wd;
            end else begin
                lat = 3;
                if (sz == 2'b00) begin mask = 32'hFF;   sh = 8 * (3 - off); end
                else             begin mask = 32'hFFFF; sh = 8 * (2 - off); end
                ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] e_rd, e_waddr, wr_addr;
        logic        e_err;
        int          e_lat, e_wrn, lat, wr_n, idx;
        model(wr, sz, uns, addr, wd, e_rd, e_err, e_lat, e_wrn, e_waddr);
        idx = int'(addr[7:2]);
        @(negedge clk);
        check($sformatf("%s.ready", tag), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        wr_n = 0; lat = 1; wr_addr = 32'hFFFF_FFFF;
        while (lat < 10) begin
            if (memWrite) begin wr_n++; wr_addr = address; end
            if (resp_valid) break;
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s.latency", tag), 32'(lat), 32'(e_lat));
        check($sformatf("%s.rdata", tag), resp_rdata, e_rd);
        check($sformatf("%s.error", tag), 32'(resp_error), 32'(e_err));
        check($sformatf("%s.writes", tag), 32'(wr_n), 32'(e_wrn));
        if (e_wrn > 0) check($sformatf("%s.waddr", tag), wr_addr, e_waddr);
        check($sformatf("%s.busy", tag), 32'(req_ready), 32'd0);
        check($sformatf("%s.mem", tag), dut_mem[idx], ref_mem[idx]);
    endtask

    task automatic back_to_back();
        int          acc, rsp, good;
        logic [31:0] e;
        acc = 0; rsp = 0; good = 0;
        e = ref_mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        for (int i = 0; i < 9; i++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                if (resp_rdata == e) good++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b.accepts", 32'(acc), 32'd3);
        check("b2b.responses", 32'(rsp), 32'd3);
        check("b2b.data", 32'(good), 32'd3);
    endtask

    task automatic reset_mid_rmw();
        int wr_n, rsp;
        wr_n = 0; rsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.memwrite", 32'(memWrite), 32'd0);
        check("rst.resp", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (memWrite) wr_n++;
            if (resp_valid) rsp++;
        end
        check("rst.late_writes", 32'(wr_n), 32'd0);
        check("rst.late_resp", 32'(rsp), 32'd0);
        check("rst.mem", dut_mem[12], ref_mem[12]);
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            dut_mem[i] <= v;
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.rdata", resp_rdata, 32'h0);
        check("reset.error", 32'(resp_error), 32'd0);
        check("reset.address", address, 32'h0);
        check("reset.writedata", writedata, 32'h0);
        check("reset.memwrite", 32'(memWrite), 32'd0);
        reset = 1'b0;

        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw10.literal", resp_rdata, 32'hDEADBEEF);
        do_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
        do_req("lb20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        check("lb20.literal", resp_rdata, 32'hFFFFFF80);
        do_req("lbu20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        check("lbu20.literal", resp_rdata, 32'h00000080);
        do_req("lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lh22.literal", resp_rdata, 32'h00007F01);
        do_req("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        check("lhu20.literal", resp_rdata, 32'h000080FF);
        do_req("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
        do_req("sb31", 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA);
        check("sb31.literal", dut_mem[12], 32'h11AA3344);
        do_req("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF);
        check("sh32.literal", dut_mem[12], 32'h11AABEEF);
        do_req("lw33", 1'b0, 2'b10, 1'b0, 32'h33, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
        check("lw33.trap", 32'(resp_error), 32'd1);
`else
        check("lw33.aligned", resp_rdata, 32'h11AABEEF);
`endif
        do_req("size3_ld", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        check("size3_ld.literal", 32'(resp_error), 32'd1);
        do_req("size3_st", 1'b1, 2'b11, 1'b0, 32'h44, 32'h12345678);

        reset_mid_rmw();
        back_to_back();

        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++)
            check($sformatf("final_mem[%0d]", i), dut_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the MIPS datapath: accepts one memory request from the pipeline at a time and drives the `dataMemory` port (`address`, `writedata`, `memWrite`, `readdata`). It handles byte, halfword and word accesses. Sub-word loads are extracted and sign- or zero-extended; sub-word stores use a read-modify-write sequence, because `dataMemory` writes whole 32-bit words only. It sits between the MEM-stage control and `dataMemory`.

## Interface
Parameters:
- ADDR_W, 32, byte-address width (word index = address[ADDR_W-1:2])

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_error  out  1  misaligned or illegal size
- address  out  ADDR_W  to dataMemory, always word-aligned ([1:0]=00)
- writedata  out  32  to dataMemory
- memWrite  out  1  to dataMemory write enable
- readdata  in  32  from dataMemory, combinational read of `address`

## Operation
- Byte order is big-endian: offset 0 = readdata[31:24]; halfword offset 0 = [31:16], offset 2 = [15:0].
- Request capture: a request is accepted when req_valid && req_ready at a rising edge. All request fields are registered at acceptance.
- State IDLE: req_ready=1, memWrite=0. On acceptance, the next state is chosen as follows:
  - error (size 11, or misaligned when trapping) → RESP, error=1, no memory access.
  - load → RD.
  - word store → WR.
  - byte/half store → RMW_RD.
- State RD: drive address. Sample readdata at the clock edge, extract the lane, extend it (sign unless req_unsigned; word loads ignore req_unsigned), then go to RESP.
- State RMW_RD: drive address. Capture readdata, replace the addressed byte/half lane with the low bits of req_wdata, then go to WR.
- State WR: memWrite=1 for exactly one cycle; address and writedata are held stable for that whole cycle. Next state is RESP.
- State RESP: resp_valid=1, resp_rdata/resp_error valid; req_ready=0. Next state is IDLE.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠00.
- address/writedata hold their last values outside RD/RMW_RD/WR. memWrite is 0 in every state except WR.
- A new request can be accepted in the cycle following RESP; there is no back-to-back acceptance in RESP.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, address=0, writedata=0, memWrite=0; state=IDLE.
- Latency, counting cycles from the acceptance edge to the resp_valid cycle:
  - load: 2
  - word store: 2
  - byte/half store: 3
  - error: 1
- Reset asserted mid-operation: at that edge the unit enters IDLE and memWrite drops to 0. The pending request is dropped with no response, and no partial write occurs after the reset edge.
- req_valid asserted while not ready is ignored, not queued; the requester holds it.
- Outputs are all registered; there are no combinational paths from req_* to the memory port.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: misaligned requests complete with resp_error=1 after 1 cycle, and no memory access occurs.
- MAU_MISALIGN_TRAP_EN undefined: misalignment is not checked. Low address bits are forced down (half: addr[0]=0; word: addr[1:0]=00) and the access proceeds normally. resp_error is raised only for size 11.

## Test plan
- After reset, store word 0xDEADBEEF at 0x10 → memWrite high exactly one cycle with address=0x10; resp_valid 2 cycles after acceptance. Then LW 0x10 → resp_rdata=0xDEADBEEF.
- With word 0x80FF7F01 at 0x20: LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080; LH 0x22 → 0x00007F01; LHU 0x20 → 0x000080FF.
- With word 0x11223344 at 0x30: SB data 0xAA to 0x31 → RMW; memory ends at 0x11AA3344, resp at 3 cycles. SH 0xBEEF to 0x32 → 0x11AABEEF.
- With MAU_MISALIGN_TRAP_EN: LW 0x33 → resp_error=1 after 1 cycle, memWrite never asserted, resp_rdata=0. Without the macro: the same access reads 0x30.
- Reset asserted during the RMW_RD cycle of an SB → no memWrite afterwards, no resp_valid, req_ready=1 next cycle, memory unchanged.
- req_size=11 → resp_error=1 in both configurations. Back-to-back requests with req_valid held high → exactly one acceptance per IDLE visit.
